// File: rtl/pad2d_stream.sv
// pad2d_stream -- streams a SIZE_H x SIZE_W frame out with a constant border
// of PAD_T/PAD_B rows and PAD_L/PAD_R columns, in raster order.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   din        input pixel, CHANNEL lanes of N bits, lane 0 in the LSBs
//   din_vld    input valid     / din_rdy  input ready (combinational)
//   dout       registered output pixel
//   dout_vld   output valid    / dout_rdy output ready
//   dout_last  high with the final pixel of the padded frame
//   busy       high while a frame is running or an output is pending
module pad2d_stream #(
  parameter int unsigned   N       = 8,
  parameter int unsigned   CHANNEL = 3,
  parameter int unsigned   SIZE_H  = 32,
  parameter int unsigned   SIZE_W  = 32,
  parameter int unsigned   PAD_T   = 1,
  parameter int unsigned   PAD_B   = 1,
  parameter int unsigned   PAD_L   = 1,
  parameter int unsigned   PAD_R   = 1,
  parameter logic [N-1:0]  PAD_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CHANNEL*N-1:0] din,
  input  logic                 din_vld,
  output logic                 din_rdy,
  output logic [CHANNEL*N-1:0] dout,
  output logic                 dout_vld,
  input  logic                 dout_rdy,
  output logic                 dout_last,
  output logic                 busy
);

  localparam int unsigned OH = SIZE_H + PAD_T + PAD_B;
  localparam int unsigned OW = SIZE_W + PAD_L + PAD_R;
  localparam int unsigned RW = (OH > 1) ? $clog2(OH) : 1;
  localparam int unsigned CW = (OW > 1) ? $clog2(OW) : 1;

  localparam int unsigned ROW_LO = PAD_T;
  localparam int unsigned ROW_HI = PAD_T + SIZE_H;
  localparam int unsigned COL_LO = PAD_L;
  localparam int unsigned COL_HI = PAD_L + SIZE_W;

  localparam logic [CHANNEL*N-1:0] PAD_WORD = {CHANNEL{PAD_VAL}};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;

  logic [31:0] row_w;
  logic [31:0] col_w;
  logic        interior;
  logic        load_en;
  logic        advance;
  logic        col_end;
  logic        at_end;

  always_comb begin
    row_w    = 32'(row);
    col_w    = 32'(col);
    interior = (row_w >= ROW_LO) && (row_w < ROW_HI) &&
               (col_w >= COL_LO) && (col_w < COL_HI);
    load_en  = !dout_vld || dout_rdy;
    // Pad positions never wait for input; interior positions need a pixel.
    advance  = (state == RUN) && load_en && (!interior || din_vld);
    col_end  = (col == CW'(OW - 1));
    at_end   = col_end && (row == RW'(OH - 1));
    din_rdy  = (state == RUN) && interior && load_en;
    busy     = (state == RUN) || dout_vld;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      dout      <= '0;
      dout_vld  <= 1'b0;
      dout_last <= 1'b0;
    end else begin
      // The pixel that wakes the block is left on din for the first
      // interior position; the transition itself consumes nothing.
      if (state == IDLE && din_vld) begin
        state <= RUN;
      end

      if (advance) begin
        dout      <= interior ? din : PAD_WORD;
        dout_vld  <= 1'b1;
        dout_last <= at_end;
        if (at_end) begin
          state <= IDLE;
          row   <= '0;
          col   <= '0;
        end else if (col_end) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else if (dout_rdy) begin
        dout_vld  <= 1'b0;
        dout_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pad2d_stream.sv
module tb_pad2d_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] din;
  logic        din_vld;
  logic        dout_rdy;

  logic        a_din_rdy, a_dout_vld, a_dout_last, a_busy;
  logic [23:0] a_dout;
  logic        b_din_rdy, b_dout_vld, b_dout_last, b_busy;
  logic [23:0] b_dout;

  logic        sel;
  logic        o_din_rdy, o_dout_vld, o_last;
  logic [23:0] o_dout;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pad2d_stream u_a (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .din_rdy(a_din_rdy),
    .dout(a_dout), .dout_vld(a_dout_vld), .dout_rdy(dout_rdy),
    .dout_last(a_dout_last), .busy(a_busy)
  );

  pad2d_stream #(
    .N(8), .CHANNEL(3), .SIZE_H(4), .SIZE_W(4),
    .PAD_T(2), .PAD_B(0), .PAD_L(0), .PAD_R(3), .PAD_VAL(8'hFF)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .din_rdy(b_din_rdy),
    .dout(b_dout), .dout_vld(b_dout_vld), .dout_rdy(dout_rdy),
    .dout_last(b_dout_last), .busy(b_busy)
  );

  assign o_din_rdy  = sel ? b_din_rdy   : a_din_rdy;
  assign o_dout_vld = sel ? b_dout_vld  : a_dout_vld;
  assign o_last     = sel ? b_dout_last : a_dout_last;
  assign o_dout     = sel ? b_dout      : a_dout;

  logic [23:0] in_pix[$];
  logic [23:0] exp_d[$];
  bit          exp_l[$];
  logic [23:0] got_d[$];
  bit          got_l[$];
  int          got_cyc[$];
  int          pad_rdy_viol;
  int          hold_viol;
  int          accepted;
  bit          timed_out;

  // Reference: walk the padded frame; interior positions take the next
  // input pixel in order, everything else is the replicated pad value.
  task automatic build_exp(input int oh, input int ow, input int pt, input int pl,
                           input int sh, input int sw, input logic [23:0] padval,
                           input int frames);
    int idx;
    idx = 0;
    exp_d.delete();
    exp_l.delete();
    for (int f = 0; f < frames; f++)
      for (int r = 0; r < oh; r++)
        for (int c = 0; c < ow; c++) begin
          if (r >= pt && r < pt + sh && c >= pl && c < pl + sw) begin
            exp_d.push_back(in_pix[idx]);
            idx++;
          end else begin
            exp_d.push_back(padval);
          end
          exp_l.push_back(r == oh - 1 && c == ow - 1);
        end
  endtask

  task automatic ramp(input int count);
    in_pix.delete();
    for (int k = 1; k <= count; k++) in_pix.push_back(24'(k));
  endtask

  task automatic rand_pix(input int count);
    in_pix.delete();
    for (int k = 0; k < count; k++) in_pix.push_back(24'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; din_vld = 1'b0; dout_rdy = 1'b0; din = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives in_pix and collects output transfers until target outputs seen.
  task automatic run_stream(input int vld_mode, input int rdy_mode, input int target,
                            input int budget, input int oh, input int ow,
                            input int pt, input int pl, input int sh, input int sw);
    int          in_idx, pos, r, c, tot;
    bit          inter, prev_stall, done;
    logic [23:0] prev_d;
    bit          prev_l;
    in_idx = 0; tot = oh * ow; prev_stall = 0; done = 0; prev_d = '0; prev_l = 0;
    got_d.delete(); got_l.delete(); got_cyc.delete();
    pad_rdy_viol = 0; hold_viol = 0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      din_vld  = (in_idx < in_pix.size()) && (vld_mode == 0 || (k % 2) == 0);
      din      = (in_idx < in_pix.size()) ? in_pix[in_idx] : 24'd0;
      dout_rdy = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (prev_stall && (o_dout_vld !== 1'b1 || o_dout !== prev_d || o_last !== prev_l))
        hold_viol++;
      pos   = (got_d.size() + (o_dout_vld ? 1 : 0)) % tot;
      r     = pos / ow;
      c     = pos % ow;
      inter = (r >= pt && r < pt + sh && c >= pl && c < pl + sw);
      if (o_din_rdy === 1'b1 && !inter) pad_rdy_viol++;
      if (din_vld && o_din_rdy === 1'b1) in_idx++;
      if (o_dout_vld === 1'b1 && dout_rdy) begin
        got_d.push_back(o_dout);
        got_l.push_back(o_last);
        got_cyc.push_back(k);
      end
      prev_stall = (o_dout_vld === 1'b1) && !dout_rdy;
      prev_d = o_dout;
      prev_l = o_last;
      if (got_d.size() >= target) done = 1;
    end
    @(posedge clk);
    #1;
    din_vld  = 1'b0;
    dout_rdy = 1'b1;
    timed_out = (got_d.size() < target);
    accepted  = in_idx;
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < exp_d.size(); i++) begin
      tests_run++;
      if (i >= got_d.size()) begin
        tests_failed++;
        $display("FAIL %s out#%0d missing, required %h last=%0d", tag, i + 1, exp_d[i], exp_l[i]);
      end else if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        tests_failed++;
        $display("FAIL %s out#%0d got %h last=%0d, required %h last=%0d",
                 tag, i + 1, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    tests_run++;
    if (got_d.size() !== exp_d.size() || timed_out) begin
      tests_failed++;
      $display("FAIL %s count got %0d, required %0d (timeout=%0d)",
               tag, got_d.size(), exp_d.size(), timed_out);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; din_vld = 1'b1; dout_rdy = 1'b1; din = 24'h123456;
    repeat (2) @(negedge clk);
    #1;
    tests_run++; if (a_dout !== 24'd0)    begin tests_failed++; $display("FAIL reset_dout got %h, required 0", a_dout); end
    tests_run++; if (a_dout_vld !== 1'b0) begin tests_failed++; $display("FAIL reset_vld got %b, required 0", a_dout_vld); end
    tests_run++; if (a_dout_last !== 1'b0) begin tests_failed++; $display("FAIL reset_last got %b, required 0", a_dout_last); end
    tests_run++; if (a_busy !== 1'b0)     begin tests_failed++; $display("FAIL reset_busy got %b, required 0", a_busy); end
    tests_run++; if (a_din_rdy !== 1'b0)  begin tests_failed++; $display("FAIL reset_din_rdy got %b, required 0", a_din_rdy); end
    tests_run++; if (b_dout_vld !== 1'b0 || b_busy !== 1'b0 || b_din_rdy !== 1'b0)
      begin tests_failed++; $display("FAIL reset_b vld/busy/rdy got %b%b%b, required 000", b_dout_vld, b_busy, b_din_rdy); end
    rst_n = 1'b1; din_vld = 1'b0;
  endtask

  task automatic test_full_rate();
    sel = 0; do_reset(); ramp(1024);
    build_exp(34, 34, 1, 1, 32, 32, 24'd0, 1);
    run_stream(0, 0, 1156, 5000, 34, 34, 1, 1, 32, 32);
    compare_all("full_rate");
    tests_run++;
    if (got_d.size() > 35 && got_d[35] !== 24'd1) begin
      tests_failed++; $display("FAIL full_rate_out36 got %h, required 000001", got_d[35]);
    end
    tests_run++;
    if (accepted !== 1024) begin tests_failed++; $display("FAIL full_rate_accepted got %0d, required 1024", accepted); end
    tests_run++;
    if (pad_rdy_viol !== 0) begin tests_failed++; $display("FAIL full_rate_pad_rdy got %0d, required 0", pad_rdy_viol); end
  endtask

  task automatic test_random_backpressure();
    sel = 0; do_reset(); ramp(1024);
    build_exp(34, 34, 1, 1, 32, 32, 24'd0, 1);
    run_stream(0, 1, 1156, 12000, 34, 34, 1, 1, 32, 32);
    compare_all("backpressure");
    tests_run++;
    if (hold_viol !== 0) begin tests_failed++; $display("FAIL backpressure_hold got %0d, required 0", hold_viol); end
  endtask

  task automatic test_din_toggle();
    sel = 0; do_reset(); rand_pix(1024);
    build_exp(34, 34, 1, 1, 32, 32, 24'd0, 1);
    run_stream(1, 0, 1156, 8000, 34, 34, 1, 1, 32, 32);
    compare_all("din_toggle");
    tests_run++;
    if (pad_rdy_viol !== 0) begin tests_failed++; $display("FAIL din_toggle_pad_rdy got %0d, required 0", pad_rdy_viol); end
    tests_run++;
    if (accepted !== 1024) begin tests_failed++; $display("FAIL din_toggle_accepted got %0d, required 1024", accepted); end
  endtask

  task automatic test_small_frame();
    sel = 1; do_reset(); rand_pix(16);
    build_exp(6, 7, 2, 0, 4, 4, 24'hFFFFFF, 1);
    run_stream(0, 1, 42, 1000, 6, 7, 2, 0, 4, 4);
    compare_all("small_frame");
    tests_run++;
    if (pad_rdy_viol !== 0 || hold_viol !== 0) begin
      tests_failed++; $display("FAIL small_frame_viol got pad=%0d hold=%0d, required 0/0", pad_rdy_viol, hold_viol);
    end
    sel = 0;
  endtask

  task automatic test_reset_midframe();
    sel = 0; do_reset(); ramp(1024);
    run_stream(0, 0, 500, 2000, 34, 34, 1, 1, 32, 32);
    tests_run++;
    if (timed_out) begin tests_failed++; $display("FAIL midreset_reach500 got %0d outputs, required 500", got_d.size()); end
    @(negedge clk);
    rst_n = 1'b0; din_vld = 1'b1; dout_rdy = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; din_vld = 1'b0;
    #1;
    tests_run++;
    if (a_dout_vld !== 1'b0 || a_busy !== 1'b0 || a_din_rdy !== 1'b0) begin
      tests_failed++; $display("FAIL midreset_clear vld/busy/rdy got %b%b%b, required 000", a_dout_vld, a_busy, a_din_rdy);
    end
    build_exp(34, 34, 1, 1, 32, 32, 24'd0, 1);
    run_stream(0, 0, 1156, 5000, 34, 34, 1, 1, 32, 32);
    compare_all("after_reset");
  endtask

  task automatic test_back_to_back();
    int nlast;
    sel = 0; do_reset(); ramp(2048);
    build_exp(34, 34, 1, 1, 32, 32, 24'd0, 2);
    run_stream(0, 0, 2312, 8000, 34, 34, 1, 1, 32, 32);
    compare_all("back_to_back");
    nlast = 0;
    foreach (got_l[i]) if (got_l[i]) nlast++;
    tests_run++;
    if (nlast !== 2) begin tests_failed++; $display("FAIL b2b_last_pulses got %0d, required 2", nlast); end
    tests_run++;
    if (got_cyc.size() < 1157 || got_cyc[1156] - got_cyc[1155] > 2) begin
      tests_failed++;
      $display("FAIL b2b_gap got %0d cycles, required <= 2",
               (got_cyc.size() < 1157) ? -1 : got_cyc[1156] - got_cyc[1155]);
    end
  endtask

  initial begin
    rst_n = 1'b0; din_vld = 1'b0; dout_rdy = 1'b0; din = '0; sel = 1'b0;
    test_reset();
    test_full_rate();
    test_random_backpressure();
    test_din_toggle();
    test_small_frame();
    test_reset_midframe();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pad2d_stream.md
PAD2D_STREAM -- requirements
Module: pad2d_stream

Interface
REQ-001 SHALL have parameter N, default 8, bit width of one channel sample.
REQ-002 SHALL have parameter CHANNEL, default 3, samples packed per pixel word.
REQ-003 SHALL have parameters SIZE_H / SIZE_W, default 32 / 32, input frame rows / columns.
REQ-004 SHALL have parameters PAD_T, PAD_B, PAD_L, PAD_R, default 1 each, pad widths 0..7 (independent per side).
REQ-005 SHALL have parameter PAD_VAL, default 0, N-bit constant replicated across all CHANNEL lanes of every pad pixel.
REQ-006 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-007 SHALL have port rst_n  in  1  synchronous, active-low reset.
REQ-008 SHALL have port din  in  CHANNEL*N  input pixel, channel 0 in LSBs.
REQ-009 SHALL have port din_vld  in  1 and port din_rdy  out  1, input handshake; transfer when both high.
REQ-010 SHALL have port dout  out  CHANNEL*N  registered output pixel.
REQ-011 SHALL have port dout_vld  out  1 and port dout_rdy  in  1, output handshake; transfer when both high.
REQ-012 SHALL have port dout_last  out  1, high with the final pixel of the padded frame.
REQ-013 SHALL have port busy  out  1, high while a frame is in progress.

Function
REQ-014 SHALL emit the padded frame in raster order, OH=SIZE_H+PAD_T+PAD_B rows by OW=SIZE_W+PAD_L+PAD_R columns, row/col counters sized $clog2(OH)/$clog2(OW).
- Position (r,c) is interior iff PAD_T<=r<PAD_T+SIZE_H and PAD_L<=c<PAD_L+SIZE_W; otherwise pad.
REQ-015 SHALL implement states IDLE and RUN; IDLE->RUN when din_vld=1 (first input pixel present, not consumed by the transition); RUN->IDLE when position (OH-1,OW-1) is loaded into the output register.
REQ-016 SHALL, in RUN, advance one position per cycle when output register can load (load_en = !dout_vld || dout_rdy) and either the position is pad, or it is interior and din_vld=1.
REQ-017 SHALL drive din_rdy = RUN & interior position & load_en (combinational); din_rdy=0 in IDLE and at pad positions.
REQ-018 SHALL load dout with PAD_VAL replicated for pad positions and with din for interior positions; latency from input acceptance to dout_vld = 1 cycle.
REQ-019 SHALL hold dout, dout_vld, dout_last stable while dout_vld=1 and dout_rdy=0.
REQ-020 SHALL clear dout_vld on a cycle where dout_rdy=1 and no new position is loaded.
REQ-021 SHALL assert dout_last only with the (OH-1,OW-1) pixel; busy = RUN or dout_vld.
REQ-022 SHALL, at interior position with din_vld=0, stall (no advance, no pad inserted early).
REQ-023 SHALL support back-to-back frames: din_vld high in IDLE on the cycle after RUN->IDLE starts the next frame with no idle gap beyond that cycle.
REQ-024 SHALL handle any PAD_* = 0 (no rows/columns for that side); all-zero pads give a pure registered pass-through.

Reset
REQ-025 SHALL, while rst_n=0 at a clk edge, set state IDLE, counters 0, dout=0, dout_vld=0, dout_last=0; din_rdy, busy read 0.
REQ-026 SHALL abandon any frame on reset mid-frame; the next frame after reset starts at position (0,0).

Verification
REQ-027 Defaults, din_vld held 1, dout_rdy held 1, din ramp 1..1024 -> 1156 outputs; first 35 and last 35 equal 0, output #36 = pixel 1, dout_last on #1156 only.
REQ-028 Defaults, random dout_rdy 50% -> output sequence identical to REQ-027; dout never changes while dout_vld=1 & dout_rdy=0.
REQ-029 Defaults, din_vld toggled every other cycle -> din_rdy never high at pad positions, no duplicated or dropped input pixels.
REQ-030 PAD_T=2,PAD_B=0,PAD_L=0,PAD_R=3,SIZE 4x4,PAD_VAL=8'hFF -> 6x7 frame, rows 0-1 all FF, columns 4-6 FF, 16 inputs in order.
REQ-031 rst_n low for 1 cycle at output #500 -> dout_vld=0 next cycle; following frame reproduces REQ-027 exactly.
REQ-032 Two frames back-to-back, din_vld continuous -> 2312 outputs, exactly two dout_last pulses, at most one cycle gap between frames.
